// File: rtl/alu32_nibble_seq_pkg.sv
// Shared constants and encodings for the nibble-serial 32-bit ALU.
package alu32_nibble_seq_pkg;

    localparam int unsigned Width = 32;
    localparam int unsigned Slice = 4;
    localparam int unsigned NPass = Width / Slice;
    localparam int unsigned CntW  = $clog2(NPass);

    // alu_ctrl[1:0] operation encodings
    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpSlt = 2'b11;

    // alu_ctrl bit positions
    localparam int unsigned CtrlAInv = 3;
    localparam int unsigned CtrlBInv = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/alu32_nibble_seq_if.sv
// Start/done handshake plus operand and result bus of the nibble-serial ALU.
interface alu32_nibble_seq_if;
    import alu32_nibble_seq_pkg::*;

    logic             start;
    logic [Width-1:0] src1;
    logic [Width-1:0] src2;
    logic [3:0]       alu_ctrl;
    logic             ready;
    logic             done;
    logic [Width-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output start, src1, src2, alu_ctrl,
        input  ready, done, result, zero, cout, overflow
    );

    modport slave (
        input  start, src1, src2, alu_ctrl,
        output ready, done, result, zero, cout, overflow
    );

endinterface

// File: rtl/alu32_nibble_seq_alu_4.sv
// 4-bit ALU slice: AND / OR / ADD / SLT-less with optional operand inversion.
module alu_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic [3:0] result,
    output logic       cout
);
    logic [3:0] aa;
    logic [3:0] bb;
    logic [4:0] sum;

    assign aa   = a ^ {4{a_invert}};
    assign bb   = b ^ {4{b_invert}};
    assign sum  = {1'b0, aa} + {1'b0, bb} + {4'b0000, cin};
    assign cout = sum[4];

    // Select the slice output for the requested operation
    always_comb begin
        result = 4'b0000;
        case (op)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum[3:0];
            default: result = {3'b000, less};
        endcase
    end

endmodule

// File: rtl/alu32_nibble_seq.sv
// Multi-cycle 32-bit ALU: one 4-bit slice reused LSB nibble first, flags at the end.
module alu32_nibble_seq
    import alu32_nibble_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu32_nibble_seq_if.slave bus
);
    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic [Width-1:0] a_q;
    logic [Width-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic [Width-1:0] acc_q;
    logic [Width-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic [1:0]       slice_op;
    logic [Slice-1:0] slice_res;
    logic             slice_cout;
    logic [Width-1:0] sum_full;
    logic [Width-1:0] res_next;
    logic             arith;
    logic             a31;
    logic             b31;
    logic             s31;
    logic             ovf_raw;
    logic             last_pass;

    // SLT runs the slice as a plain adder; the less bit is formed at the end
    assign slice_op = (ctrl_q[1:0] == OpSlt) ? OpAdd : ctrl_q[1:0];

    alu_4 u_alu_4 (
        .a        (a_q[{cnt_q, 2'b00} +: Slice]),
        .b        (b_q[{cnt_q, 2'b00} +: Slice]),
        .a_invert (ctrl_q[CtrlAInv]),
        .b_invert (ctrl_q[CtrlBInv]),
        .cin      (carry_q),
        .less     (1'b0),
        .op       (slice_op),
        .result   (slice_res),
        .cout     (slice_cout)
    );

    assign last_pass = (cnt_q == CntW'(NPass - 1));
    assign arith     = ctrl_q[1];
    assign a31       = a_q[Width-1] ^ ctrl_q[CtrlAInv];
    assign b31       = b_q[Width-1] ^ ctrl_q[CtrlBInv];
    assign s31       = slice_res[Slice-1];
    assign ovf_raw   = (a31 == b31) && (s31 != a31);

    // Final-pass result: accumulated low nibbles merged with the live top nibble
    always_comb begin
        sum_full = acc_q;
        sum_full[Width-Slice +: Slice] = slice_res;
        res_next = sum_full;
        if (ctrl_q[1:0] == OpSlt) begin
            res_next = {{(Width - 1){1'b0}}, s31 ^ ovf_raw};
        end
    end

    // Control FSM, nibble sequencing and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        a_q     <= bus.src1;
                        b_q     <= bus.src2;
                        ctrl_q  <= bus.alu_ctrl;
                        cnt_q   <= '0;
                        carry_q <= bus.alu_ctrl[CtrlBInv];
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q[{cnt_q, 2'b00} +: Slice] <= slice_res;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_pass) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        result_q <= res_next;
                        zero_q   <= (res_next == '0);
                        cout_q   <= arith & slice_cout;
                        ovf_q    <= arith & ovf_raw;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready    = (state_q != StRun);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule
